sw_debounce: RTL
================

# sw_debounce

Synchronises and debounces a bank of raw mechanical switch/button inputs, producing clean level outputs plus single-cycle rise/fall pulses. Sits directly upstream of the board's combinational gate logic: `sw_clean[2:0]` drive its three single-bit logic inputs. Each bit is handled independently by a stable-count filter, so switch bounce never reaches downstream logic.

## Interface
- `WIDTH`, 3: number of independent switch inputs.
- `STABLE_CYCLES`, 1_000_000: consecutive clock cycles a synchronised input must differ from the current clean value before clean updates (10 ms at 100 MHz); legal range ≥ 1.
- `clk`  input  1  single system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sw_in`  input  WIDTH  raw asynchronous switch levels.
- `sw_clean`  output  WIDTH  debounced level per bit.
- `rise`  output  WIDTH  one-cycle pulse when `sw_clean[i]` goes 0→1.
- `fall`  output  WIDTH  one-cycle pulse when `sw_clean[i]` goes 1→0.
- `settling`  output  WIDTH  1 while bit i's synchronised input differs from `sw_clean[i]`.

## Operation
- Per bit: 2-flop synchroniser `s1 <= sw_in[i]; s2 <= s1`; all filtering uses `s2` only.
- Per bit counter `cnt`, width `CNT_W = max(1, $clog2(STABLE_CYCLES))`, localparam.
- Per-bit states: STABLE (`s2 == clean`) and COUNTING (`s2 != clean`); no explicit state register, derived from the comparison.
- Each edge, per bit:
  - `s2 == clean`: `cnt <= 0`; no pulse.
  - `s2 != clean` and `cnt == STABLE_CYCLES-1`: `clean <= s2`, `cnt <= 0`, `rise`/`fall` asserted per new value.
  - otherwise: `cnt <= cnt + 1`.
- Bounce back to the old value before terminal count returns the bit to STABLE and clears `cnt`; the count restarts from 0 on the next difference.
- `rise`, `fall`, `sw_clean` are registered; `rise[i] & fall[i]` never both 1.
- `settling[i] = (s2 != clean)`, combinational from registers.
- Bits share no state; simultaneous changes on several bits are filtered independently and may pulse in the same cycle.
- Counter never wraps: it is cleared at terminal count or on match.

## Timing
- Reset (`rst` high at an edge): `s1`, `s2`, `sw_clean`, `cnt`, `rise`, `fall` all 0; `settling` therefore 0. Held inputs at 1 after reset produce a rise after the full filter delay.
- Latency: input level change first sampled into `s1` at edge k → `sw_clean` and pulse update at edge k+1+STABLE_CYCLES, provided `s2` stays at the new value for edges k+2..k+1+STABLE_CYCLES.
- Pulse width exactly one cycle; next possible opposite pulse on the same bit ≥ STABLE_CYCLES+... cycles later (minimum STABLE_CYCLES).
- `rst` asserted mid-count: count discarded, outputs 0 on the following cycle, no pulse emitted for the aborted change.
- `STABLE_CYCLES = 1`: clean follows `s2` one edge later (pure 3-cycle delay with edge detect).

## Structure
- Shared package `debounce_pkg`: `DEFAULT_STABLE_CYCLES` (1_000_000), `SIM_STABLE_CYCLES` (4), clock-frequency constant used to derive them.
- One sub-module `debounce_bit` (synchroniser, counter, clean register, rise/fall pulses for one bit), instantiated WIDTH times via generate loop in `sw_debounce`.

## Test plan
- Reset with `sw_in=3'b111`, STABLE_CYCLES=4: outputs 0 during/after reset; `sw_clean=3'b111` and `rise=3'b111` for one cycle exactly 5 edges after first sampled edge.
- Clean step on bit 0, 0→1 held: `settling[0]` high 4 cycles, `rise[0]` single pulse, `sw_clean[0]=1`, `fall=0` throughout.
- Bounce: bit 1 toggles 1,0,1,0 each cycle then holds 1: no pulse until 4 stable cycles after final transition; exactly one `rise[1]`.
- Glitch of 3 cycles (< STABLE_CYCLES) on bit 2 high: `sw_clean[2]` stays 0, no `rise`/`fall`, `settling[2]` returns 0.
- Simultaneous: bit 0 rises, bit 2 falls same cycle (from 3'b100): `rise=3'b001`, `fall=3'b100` in same cycle, `sw_clean=3'b001`.
- `rst` pulsed after 2 counting cycles: no pulse emitted, all outputs 0 next cycle, filtering restarts from zero count.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants for the switch debouncer: filter lengths derived from the
// system clock, plus the counter-width helper used by each per-bit filter.
package debounce_pkg;

    localparam int CLK_FREQ_HZ           = 100_000_000;
    localparam int DEBOUNCE_MS           = 10;
    localparam int DEFAULT_STABLE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int SIM_STABLE_CYCLES     = 4;

    // A filter of one cycle still needs a 1-bit counter to hold its compare value.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch: 2-flop synchroniser, stable-count filter, clean level
// register and single-cycle rise/fall pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STABLE   | s2 == sw_clean; counter held at 0
// COUNTING | s2 != sw_clean; counter runs toward STABLE_CYCLES-1
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_clean,
    output logic rise,
    output logic fall,
    output logic settling
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            sw_clean <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            s1   <= sw_in;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == sw_clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Terminal count: accept the new level and restart from zero.
                sw_clean <= s2;
                cnt      <= '0;
                rise     <= s2;
                fall     <= ~s2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign settling = s2 ^ sw_clean;

endmodule

// File: rtl/sw_debounce.sv
// Bank of independent switch debouncers feeding the board's gate logic; each
// bit is filtered on its own with no shared state.
module sw_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] settling
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .sw_in    (sw_in[i]),
            .sw_clean (sw_clean[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .settling (settling[i])
        );
    end

endmodule
